// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and helpers for the CIC interpolator/decimator pair.
//   clog2         - ceiling log2 usable in constant expressions
//   log_rate      - bits of growth per stage for a given rate
//   acc_width     - comb/integrator register width
//   out_slice_msb - top bit of the unity-gain output slice of the last integrator
package cic_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = value - 1;
    while (rem != 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned log_rate(input int unsigned rate);
    return clog2(rate);
  endfunction

  function automatic int unsigned acc_width(input int unsigned in_width,
                                            input int unsigned stages,
                                            input int unsigned rate);
    return in_width + stages * log_rate(rate);
  endfunction

  // Gain is R^(N-1): dropping (N-1)*log2(R) LSBs restores unity DC gain.
  function automatic int unsigned out_slice_msb(input int unsigned in_width,
                                                input int unsigned stages,
                                                input int unsigned rate);
    return in_width + (stages - 1) * log_rate(rate) - 1;
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// cic_interpolator_if: sample-stream bundle between upstream, the interpolator and downstream.
//   strobe     - high-rate sample enable (upstream -> DUT)
//   in_data    - signed low-rate input sample (upstream -> DUT)
//   in_req     - one-clock request for the next input sample (DUT -> upstream)
//   out_data   - signed high-rate output sample (DUT -> downstream)
//   out_strobe - one-clock pulse, out_data updated (DUT -> downstream)
interface cic_interpolator_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                        strobe;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_req;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_strobe;

  modport master (
    output strobe,
    output in_data,
    input  in_req,
    input  out_data,
    input  out_strobe
  );

  modport slave (
    input  strobe,
    input  in_data,
    output in_req,
    output out_data,
    output out_strobe
  );
endinterface

// File: rtl/cic_integrator.sv
// cic_integrator: one CIC integrator stage, o_acc <= o_acc + i_data on every strobe.
//   i_clk    - clock
//   i_rst    - asynchronous active-high reset, clears the accumulator
//   i_strobe - accumulate enable
//   i_data   - stage input (previous stage accumulator or zero-stuffed comb output)
//   o_acc    - registered accumulator, wraps in two's complement
module cic_integrator #(
  parameter int unsigned ACC_WIDTH = 31
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_strobe,
  input  logic [ACC_WIDTH-1:0] i_data,
  output logic [ACC_WIDTH-1:0] o_acc
);

  logic [ACC_WIDTH-1:0] r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_strobe) begin
      r_acc <= r_acc + i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: fixed-rate CIC interpolator (STAGES combs at the input rate, zero-stuffing,
// STAGES integrators at the output rate), output scaled back to unity DC gain.
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset, clears all state and outputs
//   io_bus - slave side of cic_interpolator_if (strobe/in_data in, in_req/out_data/out_strobe out)
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned RATE      = 8,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cic_interpolator_if.slave   io_bus
);

  localparam int unsigned LogRate  = log_rate(RATE);
  localparam int unsigned AccWidth = acc_width(IN_WIDTH, STAGES, RATE);
  localparam int unsigned OutMsb   = out_slice_msb(IN_WIDTH, STAGES, RATE);
  localparam logic [LogRate-1:0] PhaseLast = LogRate'(RATE - 1);

  logic [LogRate-1:0]          r_phase;
  logic                        w_phase_zero;
  logic                        w_accept;
  logic                        r_in_req;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_strobe;

  // w_comb_x[0] is the sign-extended input, w_comb_x[k+1] is comb stage k output.
  logic [AccWidth-1:0] w_comb_x [STAGES+1];
  // w_int_x[0] is the zero-stuffed integrator input, w_int_x[k+1] is integrator k output.
  logic [AccWidth-1:0] w_int_x  [STAGES+1];
  logic                w_unused_acc;

  assign w_phase_zero = (r_phase == '0);
  assign w_accept     = io_bus.strobe && w_phase_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (io_bus.strobe) begin
      r_phase <= (r_phase == PhaseLast) ? '0 : r_phase + 1'b1;
    end
  end

  assign w_comb_x[0] = {{(AccWidth - IN_WIDTH){io_bus.in_data[IN_WIDTH-1]}}, io_bus.in_data};

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic [AccWidth-1:0] r_comb;
    logic [AccWidth-1:0] r_dly;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_comb <= '0;
        r_dly  <= '0;
      end else if (w_accept) begin
        r_comb <= w_comb_x[k] - r_dly;
        r_dly  <= w_comb_x[k];
      end
    end

    assign w_comb_x[k+1] = r_comb;
  end

  // Comb result enters only on the phase-0 strobe; the other RATE-1 strobes feed zeros.
  assign w_int_x[0] = w_phase_zero ? w_comb_x[STAGES] : '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_int
    cic_integrator #(
      .ACC_WIDTH (AccWidth)
    ) u_integrator (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_strobe (io_bus.strobe),
      .i_data   (w_int_x[k]),
      .o_acc    (w_int_x[k+1])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_req     <= 1'b0;
      r_out_data   <= '0;
      r_out_strobe <= 1'b0;
    end else begin
      r_in_req     <= w_accept;
      r_out_strobe <= io_bus.strobe;
      if (io_bus.strobe) begin
        r_out_data <= w_int_x[STAGES][OutMsb -: OUT_WIDTH];
      end
    end
  end

  // Bits outside the output slice are intentionally discarded (floor truncation, known headroom).
  assign w_unused_acc = ^w_int_x[STAGES];

  assign io_bus.in_req     = r_in_req;
  assign io_bus.out_data   = r_out_data;
  assign io_bus.out_strobe = r_out_strobe;

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed self-checking bench for cic_interpolator with STAGES=3, RATE=8.
// Expected outputs come from the hand-derived impulse response of three length-8 boxcars.
module tb_cic_interpolator;

  localparam int unsigned STAGES    = 3;
  localparam int unsigned RATE      = 8;
  localparam int unsigned IN_WIDTH  = 16;
  localparam int unsigned OUT_WIDTH = 16;
  // Out-strobe index at which sample 0 first shows: 3 input samples of comb delay (24 strobes)
  // plus two integrator registers and the output register.
  localparam int Lat = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   h_tab [22];

  always #5 clk = ~clk;

  cic_interpolator_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  cic_interpolator #(
    .STAGES    (STAGES),
    .RATE      (RATE),
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  task automatic check(input string tag, input int obs, input int exp_val);
    checks++;
    assert (obs === exp_val) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sum of impulse-response taps that land on output phase m (DC gain is 64 once settled).
  function automatic int poly_sum(input int m);
    int s;
    s = 0;
    for (int k = 0; k * 8 <= m; k++) begin
      if (m - k * 8 <= 21) s += h_tab[m - k * 8];
    end
    return s;
  endfunction

  function automatic int exp_dc(input int x, input int n);
    if (n < Lat) return 0;
    return (x * poly_sum(n - Lat)) >>> 6;
  endfunction

  function automatic int exp_imp(input int n);
    if (n < Lat || n > Lat + 21) return 0;
    return 64 * h_tab[n - Lat];
  endfunction

  // Reset, then release it between strobes with the DC/first sample already on in_data.
  task automatic start_run(input int x);
    rst         = 1'b1;
    bus.strobe  = 1'b0;
    bus.in_data = 16'(x);
    tick();
    rst = 1'b0;
    tick();
    check("idle_out_strobe", int'(bus.out_strobe), 0);
  endtask

  task automatic run_dc_every_clock(input string tag, input int x, input int n_strobes);
    bus.strobe = 1'b1;
    for (int t = 0; t < n_strobes; t++) begin
      tick();
      check({tag, "_out_strobe"}, int'(bus.out_strobe), 1);
      check({tag, "_in_req"}, int'(bus.in_req), (t % 8 == 0) ? 1 : 0);
      check({tag, "_out_data"}, int'(bus.out_data), exp_dc(x, t));
    end
  endtask

  initial begin
    int sum;
    int nonzero;

    h_tab = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
              48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};
    bus.strobe  = 1'b0;
    bus.in_data = '0;

    // Reset held with random activity: everything stays at zero.
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.strobe  = 1'($urandom_range(0, 1));
      bus.in_data = 16'($urandom);
      tick();
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_strobe", int'(bus.out_strobe), 0);
      check("rst_in_req", int'(bus.in_req), 0);
    end

    // DC 1000, strobe every clock.
    start_run(1000);
    run_dc_every_clock("dc1000", 1000, Lat + 40);

    // Mid-stream asynchronous reset, applied away from the clock edge.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_data", int'(bus.out_data), 0);
    check("async_rst_out_strobe", int'(bus.out_strobe), 0);
    check("async_rst_in_req", int'(bus.in_req), 0);
    tick();
    check("held_rst_out_data", int'(bus.out_data), 0);
    check("held_rst_out_strobe", int'(bus.out_strobe), 0);

    // Impulse 4096 for one accept, then zeros; also proves all state was cleared.
    start_run(4096);
    bus.strobe = 1'b1;
    sum        = 0;
    nonzero    = 0;
    for (int t = 0; t < Lat + 22 + 16; t++) begin
      tick();
      if (bus.in_req) bus.in_data = '0;
      check("imp_out_data", int'(bus.out_data), exp_imp(t));
      sum += int'(bus.out_data);
      if (bus.out_data != 0) nonzero++;
    end
    check("imp_sum", sum, 32768);
    check("imp_nonzero_len", nonzero, 22);

    // Full-scale DC in both polarities.
    start_run(-32768);
    run_dc_every_clock("dcneg", -32768, Lat + 40);
    check("dcneg_final", int'(bus.out_data), -32768);
    start_run(32767);
    run_dc_every_clock("dcpos", 32767, Lat + 40);
    check("dcpos_final", int'(bus.out_data), 32767);

    // Strobe every third clock: same sequence per out_strobe, in_req every 24 clocks.
    start_run(1000);
    for (int c = 0; c < 3 * (Lat + 40); c++) begin
      bus.strobe = (c % 3 == 0);
      tick();
      check("gap_out_strobe", int'(bus.out_strobe), (c % 3 == 0) ? 1 : 0);
      check("gap_in_req", int'(bus.in_req), (c % 24 == 0) ? 1 : 0);
      check("gap_out_data", int'(bus.out_data), exp_dc(1000, c / 3));
    end
    check("gap_final", int'(bus.out_data), 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
